// File: rtl/bomb_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : bomb_pkg
//  Purpose   : Shared constants for the bomb-defusal game controller:
//              state encoding, register offsets, CTRL bit positions and
//              the strike LED thermometer helper.
//  Revision  : 1.0  initial release
// ============================================================================
package bomb_pkg;

    // Game state encoding (also the value read back from CTRL)
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_DEFUSED  = 2'd2;
    localparam logic [1:0] ST_EXPLODED = 2'd3;

    // Word offsets from the peripheral base address
    localparam logic [1:0] OFF_CTRL    = 2'd0;
    localparam logic [1:0] OFF_TIME    = 2'd1;
    localparam logic [1:0] OFF_STRIKES = 2'd2;
    localparam logic [1:0] OFF_SOLVED  = 2'd3;

    // CTRL write bit positions
    localparam int CTRL_ARM_BIT   = 0;
    localparam int CTRL_ABORT_BIT = 1;

    // Thermometer code of min(n,3) for the three strike LEDs
    function automatic logic [2:0] led_therm(input logic [7:0] n);
        logic [2:0] r;
        if (n >= 8'd3)      r = 3'b111;
        else if (n == 8'd2) r = 3'b011;
        else if (n == 8'd1) r = 3'b001;
        else                r = 3'b000;
        return r;
    endfunction

endpackage : bomb_pkg
`default_nettype wire

// File: rtl/sec_prescaler.sv
`default_nettype none
// ============================================================================
//  Module    : sec_prescaler
//  Purpose   : Free-running divider that counts 0..CLK_HZ-1 while enabled
//              and flags the terminal count, producing one tick per second.
//  Revision  : 1.0  initial release
// ============================================================================
module sec_prescaler #(
    parameter int CLK_HZ = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_tc;

    assign w_tc   = (r_cnt == CW'(CLK_HZ - 1));
    // A clear in the same cycle suppresses the tick so a dying count never fires
    assign o_tick = i_en && w_tc && !i_clr;

    // Count while enabled, wrap at terminal count, synchronous clear
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_tc ? '0 : r_cnt + CW'(1);
        end
    end

endmodule : sec_prescaler
`default_nettype wire

// File: rtl/bomb_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module    : bomb_game_ctrl
//  Purpose   : Central game sequencer. Owns the countdown, strike count and
//              game FSM, exposes them as a 4-word bus peripheral, drives the
//              timer display value and strike LEDs.
//  Revision  : 1.0  initial release
// ============================================================================
module bomb_game_ctrl
    import bomb_pkg::*;
#(
    parameter int          CLK_HZ       = 50000000,
    parameter int          MAX_STRIKES  = 3,
    parameter int          NUM_MODULES  = 4,
    parameter int          DEFAULT_SECS = 300,
    parameter logic [15:0] ADDR_BASE    = 16'hF330
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   we,
    input  logic [15:0]            addr,
    input  logic [15:0]            data,
    output logic [15:0]            q,
    input  logic [NUM_MODULES-1:0] strike_pulse,
    input  logic [NUM_MODULES-1:0] solved,
    output logic [15:0]            secs_left,
    output logic [2:0]             leds,
    output logic [1:0]             state,
    output logic                   tick
);

    // Strike counter width, and a sum wide enough to never wrap before saturation
    localparam int SW   = $clog2(MAX_STRIKES + 1);
    localparam int PW   = $clog2(NUM_MODULES + 1);
    localparam int SUMW = $clog2(MAX_STRIKES + NUM_MODULES + 1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [15:0]     r_secs;
    logic [SW-1:0]   r_strikes;
    logic [15:0]     r_q;

    logic [15:0]     w_off;
    logic            w_hit;
    logic [1:0]      w_reg;
    logic            w_wr;
    logic            w_abort;
    logic            w_arm;
    logic            w_time_wr;
    logic            w_strk_wr;
    logic [PW-1:0]   w_pop;
    logic [SUMW-1:0] w_sum;
    logic [SW-1:0]   w_strikes_sat;
    logic            w_explode;
    logic            w_tick;
    logic            w_psc_clr;
    logic            w_armed;
    logic [15:0]     w_rdata;

    // ---------------- bus decode ----------------
    assign w_off     = addr - ADDR_BASE;
    assign w_hit     = (w_off[15:2] == 14'd0);
    assign w_reg     = w_off[1:0];
    assign w_wr      = en && we && w_hit;
    assign w_abort   = w_wr && (w_reg == OFF_CTRL) && data[CTRL_ABORT_BIT];
    assign w_arm     = w_wr && (w_reg == OFF_CTRL) && data[CTRL_ARM_BIT] && !data[CTRL_ABORT_BIT];
    assign w_time_wr = w_wr && (w_reg == OFF_TIME);
    assign w_strk_wr = w_wr && (w_reg == OFF_STRIKES);

    // ---------------- strike accumulation ----------------
    // Number of modules reporting a strike this cycle
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_MODULES; i++) begin
            w_pop = w_pop + PW'(strike_pulse[i]);
        end
    end

    assign w_sum         = SUMW'(r_strikes) + SUMW'(w_pop);
    assign w_strikes_sat = (w_sum >= SUMW'(MAX_STRIKES)) ? SW'(MAX_STRIKES) : SW'(w_sum);

    // ---------------- countdown prescaler ----------------
    assign w_armed   = (r_state == ST_ARMED);
    assign w_psc_clr = w_abort || !w_armed;

    sec_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_prescaler (
        .clk    (clk),
        .rst    (reset),
        .i_clr  (w_psc_clr),
        .i_en   (w_armed),
        .o_tick (w_tick)
    );

    assign w_explode = (w_strikes_sat == SW'(MAX_STRIKES)) || (w_tick && (r_secs == 16'd1));

    // ---------------- FSM ----------------
    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic; abort overrides everything, explosion beats defuse
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_arm && (r_secs != 16'd0)) w_state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (w_explode)   w_state_next = ST_EXPLODED;
                else if (&solved) w_state_next = ST_DEFUSED;
            end
            default: w_state_next = r_state;
        endcase
        if (w_abort) w_state_next = ST_IDLE;
    end

    // FSM-facing outputs
    always_comb begin
        state     = r_state;
        tick      = w_tick;
        secs_left = r_secs;
        leds      = led_therm(8'(r_strikes));
    end

    // ---------------- datapath ----------------
    // Countdown and strike count: loaded in IDLE, updated in ARMED, frozen otherwise
    always_ff @(posedge clk) begin
        if (reset || w_abort) begin
            r_secs    <= 16'(DEFAULT_SECS);
            r_strikes <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_time_wr) r_secs    <= data;
                    if (w_strk_wr) r_strikes <= '0;
                end
                ST_ARMED: begin
                    r_strikes <= w_strikes_sat;
                    if (w_tick) r_secs <= r_secs - 16'd1;
                end
                default: begin
                    r_secs    <= r_secs;
                    r_strikes <= r_strikes;
                end
            endcase
        end
    end

    // ---------------- read path ----------------
    // Read mux; unmapped addresses return zero
    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_reg)
                OFF_CTRL:    w_rdata = {14'd0, r_state};
                OFF_TIME:    w_rdata = r_secs;
                OFF_STRIKES: w_rdata = 16'(r_strikes);
                default:     w_rdata = 16'(solved);
            endcase
        end
    end

    // Registered read data, refreshed on every enabled bus cycle
    always_ff @(posedge clk) begin
        if (reset)   r_q <= '0;
        else if (en) r_q <= w_rdata;
    end

    assign q = r_q;

endmodule : bomb_game_ctrl
`default_nettype wire

// File: tb/tb_bomb_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module    : tb_bomb_game_ctrl
//  Purpose   : Scoreboard bench for bomb_game_ctrl (CLK_HZ=10).
//  Revision  : 1.0  initial release
// ============================================================================
module tb_bomb_game_ctrl;

    localparam logic [15:0] BASE = 16'hF330;

    typedef struct {
        string       name;
        logic [15:0] act;
        logic [15:0] exp;
    } chk_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] data = '0;
    logic [15:0] q;
    logic [3:0]  strike_pulse = '0;
    logic [3:0]  solved = '0;
    logic [15:0] secs_left;
    logic [2:0]  leds;
    logic [1:0]  state;
    logic        tick;

    logic        rd_pend = 1'b0;
    logic        done = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    logic [15:0] rd_exp_q[$];
    string       rd_name_q[$];
    chk_t        chk_q[$];

    bomb_game_ctrl #(
        .CLK_HZ       (10),
        .MAX_STRIKES  (3),
        .NUM_MODULES  (4),
        .DEFAULT_SECS (300),
        .ADDR_BASE    (BASE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .we           (we),
        .addr         (addr),
        .data         (data),
        .q            (q),
        .strike_pulse (strike_pulse),
        .solved       (solved),
        .secs_left    (secs_left),
        .leds         (leds),
        .state        (state),
        .tick         (tick)
    );

    always #5 clk = ~clk;

    // A read issued on this edge produces q visible after it
    always @(posedge clk) rd_pend <= en && !we;

    // Monitor: owns all comparison counting
    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            chk_t c;
            c = chk_q.pop_front();
            n_checks++;
            if (c.act !== c.exp) begin
                n_errors++;
                $display("FAIL %s: got %0d expected %0d", c.name, c.act, c.exp);
            end
        end
        if (rd_pend) begin
            n_checks++;
            if (rd_exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_read: got %0d expected none", q);
            end else begin
                logic [15:0] e;
                string       nm;
                e  = rd_exp_q.pop_front();
                nm = rd_name_q.pop_front();
                if (q !== e) begin
                    n_errors++;
                    $display("FAIL %s: got %0d expected %0d", nm, q, e);
                end
            end
        end
        if (done) begin
            n_checks++;
            if (rd_exp_q.size() != 0) begin
                n_errors++;
                $display("FAIL read_queue_drain: got %0d pending expected 0", rd_exp_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
            $finish;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        en = 1'b1; we = 1'b1; addr = a; data = d;
        step(1);
        en = 1'b0; we = 1'b0;
    endtask

    task automatic bus_rd(input string nm, input logic [15:0] a, input logic [15:0] e);
        rd_exp_q.push_back(e);
        rd_name_q.push_back(nm);
        en = 1'b1; we = 1'b0; addr = a;
        step(1);
        en = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] e);
        chk_t c;
        c.name = nm; c.act = act; c.exp = e;
        chk_q.push_back(c);
    endtask

    task automatic pulse(input logic [3:0] sp);
        strike_pulse = sp;
        step(1);
        strike_pulse = '0;
    endtask

    // Stimulus
    initial begin
        int n_tick;
        int first_tick;
        int last_tick;

        // Reset state
        step(3);
        reset = 1'b0;
        chk("reset_leds", 16'(leds), 16'd0);
        chk("reset_tick", 16'(tick), 16'd0);
        bus_rd("reset_ctrl",    BASE + 16'd0, 16'd0);
        bus_rd("reset_time",    BASE + 16'd1, 16'd300);
        bus_rd("reset_strikes", BASE + 16'd2, 16'd0);
        bus_rd("reset_solved",  BASE + 16'd3, 16'd0);

        // Countdown to explosion
        bus_wr(BASE + 16'd1, 16'd3);
        bus_rd("time_loaded", BASE + 16'd1, 16'd3);
        bus_wr(BASE + 16'd0, 16'd1);
        n_tick = 0; first_tick = -1; last_tick = -1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (tick) begin
                n_tick++;
                if (first_tick < 0) first_tick = k;
                last_tick = k;
            end
            if (k == 5)  chk("armed_state", 16'(state), 16'd1);
            if (k == 11) chk("secs_after_tick1", secs_left, 16'd2);
            if (k == 21) chk("secs_after_tick2", secs_left, 16'd1);
            if (k == 31) begin
                chk("secs_at_zero", secs_left, 16'd0);
                chk("exploded_on_zero", 16'(state), 16'd3);
            end
        end
        chk("tick_count", 16'(n_tick), 16'd3);
        chk("first_tick_cycle", 16'(first_tick), 16'd10);
        chk("last_tick_cycle", 16'(last_tick), 16'd30);
        step(1);
        bus_rd("exploded_ctrl", BASE + 16'd0, 16'd3);

        // Strike accumulation to explosion
        bus_wr(BASE + 16'd0, 16'd2);
        bus_wr(BASE + 16'd1, 16'd100);
        bus_wr(BASE + 16'd0, 16'd1);
        pulse(4'b0011);
        chk("strikes2_leds", 16'(leds), 16'b011);
        chk("strikes2_state", 16'(state), 16'd1);
        pulse(4'b0001);
        chk("strikes3_leds", 16'(leds), 16'b111);
        chk("strikes3_state", 16'(state), 16'd3);
        bus_rd("strikes3_read", BASE + 16'd2, 16'd3);

        // Explode beats defuse in the same cycle
        bus_wr(BASE + 16'd0, 16'd2);
        bus_wr(BASE + 16'd1, 16'd100);
        bus_wr(BASE + 16'd0, 16'd1);
        pulse(4'b0011);
        solved = 4'b1111;
        pulse(4'b0100);
        solved = 4'b0000;
        chk("explode_priority", 16'(state), 16'd3);

        // Defuse with countdown frozen
        bus_wr(BASE + 16'd0, 16'd2);
        bus_wr(BASE + 16'd0, 16'd1);
        step(12);
        chk("secs_before_defuse", secs_left, 16'd299);
        solved = 4'b1111;
        bus_rd("solved_read", BASE + 16'd3, 16'd15);
        solved = 4'b0000;
        chk("defused_state", 16'(state), 16'd2);
        step(25);
        chk("defused_secs_frozen", secs_left, 16'd299);
        chk("defused_state_held", 16'(state), 16'd2);

        // Writes ignored while ARMED, then arm+abort together
        bus_wr(BASE + 16'd0, 16'd2);
        bus_wr(BASE + 16'd0, 16'd1);
        pulse(4'b1000);
        bus_wr(BASE + 16'd1, 16'd50);
        bus_wr(BASE + 16'd2, 16'd0);
        bus_rd("armed_time_ignored",    BASE + 16'd1, 16'd300);
        bus_rd("armed_strikes_ignored", BASE + 16'd2, 16'd1);
        bus_wr(BASE + 16'd0, 16'd3);
        bus_rd("abort_ctrl",    BASE + 16'd0, 16'd0);
        bus_rd("abort_time",    BASE + 16'd1, 16'd300);
        bus_rd("abort_strikes", BASE + 16'd2, 16'd0);
        chk("abort_leds", 16'(leds), 16'd0);

        // Arm with zero seconds, unmapped address, strikes in IDLE
        bus_wr(BASE + 16'd1, 16'd0);
        bus_wr(BASE + 16'd0, 16'd1);
        bus_rd("arm_zero_ignored", BASE + 16'd0, 16'd0);
        bus_wr(BASE + 16'd5, 16'h1234);
        bus_rd("unmapped_read", BASE + 16'd5, 16'd0);
        bus_rd("unmapped_no_effect", BASE + 16'd1, 16'd0);
        pulse(4'b1111);
        bus_rd("idle_strikes_ignored", BASE + 16'd2, 16'd0);

        // Reset while ARMED acts like abort
        bus_wr(BASE + 16'd1, 16'd7);
        bus_wr(BASE + 16'd0, 16'd1);
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        bus_rd("reset_armed_ctrl", BASE + 16'd0, 16'd0);
        bus_rd("reset_armed_time", BASE + 16'd1, 16'd300);

        step(3);
        done = 1'b1;
    end

    // Bound on total run time
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_bomb_game_ctrl
`default_nettype wire

// File: doc/bomb_game_ctrl.md
Name: bomb_game_ctrl

Overview:
Central game sequencer for the bomb-defusal hardware.
- Owns the countdown seconds, the strike count and the game state machine: IDLE, ARMED, DEFUSED, EXPLODED.
- Exposes these as a memory-mapped peripheral on the 16-bit CPU bus in the extras window.
- Drives the timer display value and the strike LEDs, and collects strike/solve events from puzzle modules.

Parameters:
- CLK_HZ, 50000000, clock cycles per countdown second (prescaler terminal count + 1).
- MAX_STRIKES, 3, strike count that triggers explosion (range 1..7).
- NUM_MODULES, 4, number of puzzle modules reporting strike/solve.
- DEFAULT_SECS, 300, seconds loaded at reset and on abort.
- ADDR_BASE, 16'hF330, bus address of register offset 0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  bus cycle enable
- we  in  1  bus write strobe (qualified by en)
- addr  in  16  bus address
- data  in  16  bus write data
- q  out  16  bus read data, registered
- strike_pulse  in  NUM_MODULES  one-cycle strike pulse per module
- solved  in  NUM_MODULES  level, module solved
- secs_left  out  16  current countdown value, to display driver
- leds  out  3  strike LEDs, thermometer code
- state  out  2  0 IDLE, 1 ARMED, 2 DEFUSED, 3 EXPLODED
- tick  out  1  one-cycle pulse on each countdown decrement

Behaviour:
- Register map, word offsets from ADDR_BASE:
  - 0 CTRL: write bit0 = arm, bit1 = abort; read {14'b0, state}.
  - 1 TIME: write loads secs_left; read secs_left.
  - 2 STRIKES: write clears the count; read zero-extended count.
  - 3 SOLVED: read-only, zero-extended solved mask.
  - Any other address: writes ignored, reads return 0.
- Read latency: q is updated 1 cycle after an en=1 cycle. q holds its value when en=0.
- Reset values: state=IDLE, secs_left=DEFAULT_SECS, strike count=0, leds=000, q=0, tick=0, prescaler=0.
- IDLE:
  - TIME and STRIKES writes are accepted.
  - Arm with secs_left>0 → ARMED, prescaler cleared. Arm with secs_left=0 is ignored.
  - strike_pulse is ignored.
- ARMED:
  - Prescaler counts 0..CLK_HZ-1. At the terminal count: tick=1 for one cycle, secs_left decrements, prescaler wraps to 0.
  - Each cycle, strike count increases by popcount(strike_pulse) and saturates at MAX_STRIKES.
  - TIME and STRIKES writes are ignored.
- Transitions out of ARMED, evaluated on next-state values, priority high→low:
  - abort → IDLE.
  - next strike count ≥ MAX_STRIKES, or secs_left decrementing 1→0 → EXPLODED.
  - solved all ones → DEFUSED.
  - Simultaneous explode and defuse conditions: EXPLODED wins.
- DEFUSED and EXPLODED are terminal:
  - secs_left and strikes are frozen; no ticks; events ignored.
  - Only abort or reset leaves them.
- Abort in any state → IDLE, secs_left=DEFAULT_SECS, strikes=0, prescaler=0.
- Arm and abort in the same write: abort wins.
- Reset during ARMED behaves identically to abort.
- leds = thermometer of min(strikes,3): 0→000, 1→001, 2→011, ≥3→111.
- Strike counter width is clog2(MAX_STRIKES+1). The popcount adder must not overflow before saturation.

Decomposition:
- Shared package bomb_pkg:
  - state encoding constants
  - register offsets (CTRL, TIME, STRIKES, SOLVED)
  - CTRL bit positions
  - LED thermometer function
- Sub-module: sec_prescaler (counter with sync clear, enable, terminal-count tick output), parameterised by CLK_HZ.
- Everything else lives in bomb_game_ctrl.

Test Plan (CLK_HZ=10 in simulation):
- Reset, then read offsets 0/1/2/3 → q = 0, 300, 0, 0 one cycle after each read; leds=000.
- Write TIME=3, arm → ARMED; tick every 10 cycles; secs_left 3→2→1→0; EXPLODED on the 0 transition; no further ticks.
- ARMED with MAX_STRIKES=3: pulse strike_pulse=4'b0011, then 4'b0001 → strikes 2 then 3, leds 011 then 111, state EXPLODED in the same cycle the count reaches 3.
- ARMED: drive solved=4'b1111 in the same cycle as a strike_pulse reaching MAX → EXPLODED (priority); repeat without the strike → DEFUSED with secs_left frozen.
- In ARMED, write TIME=50 and STRIKES → ignored; then write CTRL=2'b11 → IDLE, secs_left=300, strikes=0.
- Arm with secs_left=0 (after a TIME=0 write) → stays IDLE; access addr ADDR_BASE+5 → read 0, write has no effect.
